// File: rtl/noc_pkg.sv
// Shared types and constants for the NOC return-path merger.
package noc_pkg;

  localparam logic [7:0] NOP_DATA = 8'h00;
  localparam logic [7:0] DEV_BOX0 = 8'h40;
  localparam logic [7:0] DEV_BOX1 = 8'h41;

  typedef struct packed {
    logic       ctl;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } merge_state_t;

endpackage

// File: rtl/noc_ret_fifo.sv
// Per-port byte FIFO; same-cycle write and pop both honoured, full/empty from pre-edge state.
module noc_ret_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output logic        full,
  output logic        empty,
  output logic        one_left,
  output fifo_entry_t head,
  output logic        next_ctl
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic [AW-1:0] next_idx;
  logic          do_wr, do_rd;
  fifo_entry_t   mem_q [DEPTH];

  // Occupancy, accept/pop decisions and head lookahead for frame-end detection.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == {(AW+1){1'b0}});
    one_left = (count == (AW+1)'(1'b1));
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    next_idx = rd_ptr_q[AW-1:0] + AW'(1'b1);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    next_ctl = mem_q[next_idx].ctl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/noc_return_merge.sv
// Merges the from-device byte streams of two boxes onto one stream,
// frame-atomic with round-robin arbitration over fully received frames.
module noc_return_merge
  import noc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] NOP_DATA   = noc_pkg::NOP_DATA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0_ctl,
  input  logic [7:0] in0_data,
  input  logic       in1_ctl,
  input  logic [7:0] in1_data,
  output logic       out_ctl,
  output logic [7:0] out_data,
  output logic [1:0] ovf
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    in_ctl;
  logic [7:0]    in_data [2];
  logic [1:0]    wr_en, full, empty, one_left, next_ctl;
  logic [1:0]    pop, inc, dec, elig;
  fifo_entry_t   wr_data [2];
  fifo_entry_t   head    [2];

  logic [1:0]    in_frame_q, in_frame_d;
  logic [1:0]    ovf_q, ovf_d;
  logic [CW-1:0] frame_cnt_q [2];
  logic [CW-1:0] frame_cnt_d [2];
  merge_state_t  state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          rr_q, rr_d;
  logic          pick;
  logic          out_ctl_q, out_ctl_d;
  logic [7:0]    out_data_q, out_data_d;

  always_comb begin
    in_ctl     = {in1_ctl, in0_ctl};
    in_data[0] = in0_data;
    in_data[1] = in1_data;
  end

  noc_ret_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (wr_en[0]),
    .wr_data  (wr_data[0]),
    .rd_en    (pop[0]),
    .full     (full[0]),
    .empty    (empty[0]),
    .one_left (one_left[0]),
    .head     (head[0]),
    .next_ctl (next_ctl[0])
  );

  noc_ret_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (wr_en[1]),
    .wr_data  (wr_data[1]),
    .rd_en    (pop[1]),
    .full     (full[1]),
    .empty    (empty[1]),
    .one_left (one_left[1]),
    .head     (head[1]),
    .next_ctl (next_ctl[1])
  );

  // Capture: a command or NOP closes the open frame; body bytes outside a frame are dropped.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_en[p]      = 1'b0;
      wr_data[p]    = '{ctl: 1'b0, data: in_data[p]};
      inc[p]        = 1'b0;
      in_frame_d[p] = in_frame_q[p];
      if (in_ctl[p]) begin
        inc[p] = in_frame_q[p];
        if (in_data[p] != NOP_DATA) begin
          wr_en[p]       = 1'b1;
          wr_data[p].ctl = 1'b1;
          in_frame_d[p]  = 1'b1;
        end else begin
          in_frame_d[p]  = 1'b0;
        end
      end else if (in_frame_q[p]) begin
        wr_en[p] = 1'b1;
      end else begin
        wr_en[p] = 1'b0;
      end
      ovf_d[p]       = ovf_q[p] | (wr_en[p] & full[p] & ~pop[p]);
      frame_cnt_d[p] = frame_cnt_q[p] + CW'(inc[p]) - CW'(dec[p]);
    end
  end

  // Arbiter/sender: the last granted port loses ties; a frame ends at the next stored command.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    pick       = 1'b0;
    pop        = 2'b00;
    dec        = 2'b00;
    out_ctl_d  = 1'b1;
    out_data_d = NOP_DATA;
    elig       = {frame_cnt_q[1] != {CW{1'b0}}, frame_cnt_q[0] != {CW{1'b0}}};
    case (state_q)
      IDLE: begin
        if (elig == 2'b11) begin
          pick = rr_q;
        end else begin
          pick = elig[1];
        end
        if (elig != 2'b00) begin
          gnt_d     = pick;
          rr_d      = ~pick;
          dec[pick] = 1'b1;
          state_d   = SEND;
        end else begin
          state_d   = IDLE;
        end
      end
      SEND: begin
        if (empty[gnt_q]) begin
          state_d = IDLE;
        end else begin
          pop[gnt_q] = 1'b1;
          out_ctl_d  = head[gnt_q].ctl;
          out_data_d = head[gnt_q].data;
          if (one_left[gnt_q] | next_ctl[gnt_q]) begin
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame_q     <= 2'b00;
      ovf_q          <= 2'b00;
      frame_cnt_q[0] <= {CW{1'b0}};
      frame_cnt_q[1] <= {CW{1'b0}};
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      rr_q           <= 1'b0;
      out_ctl_q      <= 1'b1;
      out_data_q     <= NOP_DATA;
    end else begin
      in_frame_q     <= in_frame_d;
      ovf_q          <= ovf_d;
      frame_cnt_q[0] <= frame_cnt_d[0];
      frame_cnt_q[1] <= frame_cnt_d[1];
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_q           <= rr_d;
      out_ctl_q      <= out_ctl_d;
      out_data_q     <= out_data_d;
    end
  end

  assign out_ctl  = out_ctl_q;
  assign out_data = out_data_q;
  assign ovf      = ovf_q;

endmodule
